// File: rtl/button_debouncer_pkg.sv
// ============================================================================
// Module      : button_debouncer_pkg
// Description : Shared definitions for the push-button debouncer: per-channel
//               FSM state encoding and default parameter values.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package button_debouncer_pkg;

  // Per-channel debounce FSM encoding.
  typedef enum logic [0:0] {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } db_state_e;

  // 10 ms of stable input at a 50 MHz system clock.
  localparam int   DEFAULT_DEBOUNCE_CYCLES = 500000;

  // Board KEY inputs are active-low, so the released level is high.
  localparam logic DEFAULT_IDLE_LEVEL      = 1'b1;

endpackage

`default_nettype wire

// File: rtl/button_debouncer_debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : Debouncer for a single push-button bit. Two-flop synchronizer,
//               STABLE/COUNTING FSM with a saturating-by-construction counter,
//               registered debounced level and registered press/release strobes.
// Revision    : 1.0 - initial release
//
// Ports
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   btn_i      in   raw asynchronous button pin
//   btn_o      out  debounced level (flop output)
//   press_o    out  one-cycle strobe when btn_o leaves IDLE_LEVEL
//   release_o  out  one-cycle strobe when btn_o returns to IDLE_LEVEL
// ============================================================================
`default_nettype none

module debounce_channel
  import button_debouncer_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic IDLE_LEVEL      = DEFAULT_IDLE_LEVEL
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_i,
  output logic btn_o,
  output logic press_o,
  output logic release_o
);

  localparam int             CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);

  logic             meta_q;
  logic             sync_q;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             out_q,   out_d;
  logic             press_q, press_d;
  logic             rel_q,   rel_d;

  // Synchronizer: nothing downstream ever looks at btn_i directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= IDLE_LEVEL;
      sync_q <= IDLE_LEVEL;
    end else begin
      meta_q <= btn_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      out_q   <= IDLE_LEVEL;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // The counter records how many consecutive edges sync_q has disagreed with
  // the current output. The edge that would make it reach DEBOUNCE_CYCLES is
  // the one that flips the output instead, so it tops out at DEBOUNCE_CYCLES-1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    case (state_q)
      ST_STABLE: begin
        cnt_d = '0;
        if (sync_q != out_q) begin
          state_d = ST_COUNTING;
          cnt_d   = C_ONE;
        end
      end
      ST_COUNTING: begin
        if (sync_q == out_q) begin
          // Bounce: input went back before the window elapsed.
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == C_LAST) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
          out_d   = ~out_q;
          // Pulses are registered alongside the output so they line up with it.
          if (out_q == IDLE_LEVEL) begin
            press_d = 1'b1;
          end else begin
            rel_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + C_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign btn_o     = out_q;
  assign press_o   = press_q;
  assign release_o = rel_q;

endmodule

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Multi-channel push-button debouncer. One independent
//               debounce_channel per button bit; no cross-channel priority.
// Revision    : 1.0 - initial release
//
// Ports
//   clk            in   [1]      system clock, rising edge
//   reset_n        in   [1]      asynchronous active-low reset
//   btn_in         in   [WIDTH]  raw button pins
//   btn_out        out  [WIDTH]  debounced levels, same polarity as btn_in
//   press_pulse    out  [WIDTH]  one-cycle strobe on leaving IDLE_LEVEL
//   release_pulse  out  [WIDTH]  one-cycle strobe on returning to IDLE_LEVEL
// ============================================================================
`default_nettype none

module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int   WIDTH           = 3,
  parameter int   DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter logic IDLE_LEVEL      = DEFAULT_IDLE_LEVEL
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] btn_in,
  output logic [WIDTH-1:0] btn_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .IDLE_LEVEL      (IDLE_LEVEL)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_i     (btn_in[gi]),
      .btn_o     (btn_out[gi]),
      .press_o   (press_pulse[gi]),
      .release_o (release_pulse[gi])
    );
  end

endmodule

`default_nettype wire
